// File: rtl/fir_stim_pkg.sv
// Shared types and constants for the FIR stimulus source: FSM states, mode
// encodings and the 16-bit LFSR polynomial.
package fir_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EMIT,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_IMPULSE = 2'd0;
    localparam logic [1:0] MODE_STEP    = 2'd1;
    localparam logic [1:0] MODE_NOISE   = 2'd2;
    localparam logic [1:0] MODE_ALT     = 2'd3;

    // Bits 15,13,12,10 realise x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/fir_stim_src_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and step enable.
// Load has priority over step.
module lfsr16
    import fir_stim_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [15:0] lfsr
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (load) begin
            lfsr <= SEED;
        end else if (step) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/fir_stim_src.sv
// Burst stimulus source for the FIR data_in/in_valid interface: impulse, step,
// noise or alternating samples with optional gaps, followed by a zero flush.
module fir_stim_src
    import fir_stim_pkg::*;
#(
    parameter int          OUT_INTE_WL = 4,
    parameter int          OUT_FRAC_WL = 12,
    parameter int          CNT_WL      = 16,
    parameter int          FLUSH_LEN   = 30,
    parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [1:0]                             mode,
    input  logic signed [OUT_INTE_WL-1:-OUT_FRAC_WL] amp,
    input  logic [CNT_WL-1:0]                      n_samples,
    input  logic [7:0]                             gap,
    output logic signed [OUT_INTE_WL-1:-OUT_FRAC_WL] data_out,
    output logic                                   out_valid,
    output logic                                   busy,
    output logic                                   done
);

    localparam int W     = OUT_INTE_WL + OUT_FRAC_WL;
    localparam int FL_WL = $clog2(FLUSH_LEN + 1);
    localparam logic [FL_WL-1:0] FLUSH_LAST = FL_WL'(FLUSH_LEN - 1);

    state_t              state;
    logic [1:0]          lat_mode;
    logic signed [W-1:0] lat_amp;
    logic [CNT_WL-1:0]   lat_n;
    logic [7:0]          lat_gap;
    logic [CNT_WL-1:0]   k;
    logic [7:0]          gap_cnt;
    logic [FL_WL-1:0]    flush_cnt;

    logic [15:0]         lfsr_q;
    logic                lfsr_load;
    logic                lfsr_step;
    logic signed [W-1:0] sample;
    logic                last_sample;

    assign lfsr_load   = (state == ST_IDLE) && start;
    assign lfsr_step   = (state == ST_EMIT) && (lat_mode == MODE_NOISE);
    assign last_sample = (k == lat_n - CNT_WL'(1));

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .lfsr (lfsr_q)
    );

    // NOTE: a default assignment ahead of the case keeps this purely
    // combinational; any path leaving sample unassigned would infer a latch.
    always_comb begin
        sample = '0;
        unique case (lat_mode)
            MODE_IMPULSE: sample = (k == '0) ? lat_amp : '0;
            MODE_STEP:    sample = lat_amp;
            MODE_NOISE:   sample = lfsr_q[15 -: W];
            default:      sample = k[0] ? -lat_amp : lat_amp;
        endcase
    end

    // Outputs are registered from the current state, so the first sample
    // appears one cycle after start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            lat_mode  <= '0;
            lat_amp   <= '0;
            lat_n     <= '0;
            lat_gap   <= '0;
            k         <= '0;
            gap_cnt   <= '0;
            flush_cnt <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    data_out  <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        lat_mode  <= mode;
                        lat_amp   <= amp;
                        lat_n     <= n_samples;
                        lat_gap   <= gap;
                        k         <= '0;
                        flush_cnt <= '0;
                        state     <= (n_samples == '0) ? ST_FLUSH : ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    data_out  <= sample;
                    out_valid <= 1'b1;
                    busy      <= 1'b1;
                    k         <= k + CNT_WL'(1);
                    // No gap follows the final sample; flush starts immediately.
                    if (last_sample) begin
                        flush_cnt <= '0;
                        state     <= ST_FLUSH;
                    end else if (lat_gap != 8'd0) begin
                        gap_cnt <= lat_gap;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    data_out  <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b1;
                    if (gap_cnt == 8'd1) begin
                        state <= ST_EMIT;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                ST_FLUSH: begin
                    data_out  <= '0;
                    out_valid <= 1'b1;
                    busy      <= 1'b1;
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        flush_cnt <= flush_cnt + FL_WL'(1);
                    end
                end
                ST_DONE: begin
                    data_out  <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b1;
                    done      <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stim_src.sv
// Scoreboard bench for fir_stim_src: expected samples and done cycles are
// queued when a burst is started and consumed by a negedge monitor.
module tb_fir_stim_src;

    typedef struct packed {
        logic [15:0] data;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] amp;
    logic [15:0] n_samples;
    logic [7:0]  gap;
    logic [15:0] data_out;
    logic        out_valid;
    logic        busy;
    logic        done;

    exp_t        sb_q[$];
    logic [31:0] done_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    fir_stim_src dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .amp       (amp),
        .n_samples (n_samples),
        .gap       (gap),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_model(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    function automatic logic [15:0] model_sample(input logic [1:0] m, input logic [15:0] a,
                                                 input int k, input logic [15:0] lf);
        case (m)
            2'd0:    return (k == 0) ? a : 16'h0000;
            2'd1:    return a;
            2'd2:    return lf;
            default: return (k % 2 == 1) ? 16'h0000 - a : a;
        endcase
    endfunction

    // Monitor: every valid sample is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sample_data", {16'h0, data_out}, {16'h0, e.data});
                    check("sample_cycle", cyc, e.cyc);
                end
            end else begin
                check("idle_data_zero", {16'h0, data_out}, 32'h0);
            end
            if (done) begin
                check("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) begin
                    check("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    // Called just after a negedge; start is sampled on the following posedge.
    task automatic start_burst(input logic [1:0] m, input logic [15:0] a,
                               input logic [15:0] n, input logic [7:0] g);
        int          s;
        int          last;
        logic [15:0] lf;
        exp_t        e;
        mode      = m;
        amp       = a;
        n_samples = n;
        gap       = g;
        start     = 1'b1;
        s  = cyc + 1;
        lf = 16'hACE1;
        for (int k = 0; k < int'(n); k++) begin
            e.data = model_sample(m, a, k, lf);
            e.cyc  = 32'(s + 1 + k * (int'(g) + 1));
            sb_q.push_back(e);
            if (m == 2'd2) lf = lfsr_model(lf);
        end
        last = (n != 16'd0) ? s + 1 + (int'(n) - 1) * (int'(g) + 1) : s;
        for (int f = 1; f <= 30; f++) begin
            e.data = 16'h0000;
            e.cyc  = 32'(last + f);
            sb_q.push_back(e);
        end
        done_q.push_back(32'(last + 31));
        @(negedge clk);
        start     = 1'b0;
        mode      = ~m;
        amp       = ~a;
        n_samples = 16'd7;
        gap       = 8'd3;
        @(negedge clk);
        check("busy_first_cycle", {31'h0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while ((done_q.size() != 0) && (i < budget)) begin
            @(negedge clk);
            #1;
            i++;
        end
        check("burst_complete", done_q.size(), 32'd0);
        check("sb_drained", sb_q.size(), 32'd0);
        @(negedge clk);
        check("busy_after_done", {31'h0, busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data"},  {16'h0, data_out}, 32'h0);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'd0);
        check({tag, "_busy"},  {31'h0, busy}, 32'd0);
        check({tag, "_done"},  {31'h0, done}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        amp       = 16'h0;
        n_samples = 16'd0;
        gap       = 8'd0;
        #7;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Impulse, n=4, no gaps.
        start_burst(2'd0, 16'h1000, 16'd4, 8'd0);
        wait_done(200);

        // Alternating with two idle cycles between samples.
        start_burst(2'd3, 16'h0800, 16'd3, 8'd2);
        wait_done(200);

        // Noise twice: the second burst must repeat the first sequence.
        start_burst(2'd2, 16'h5555, 16'd3, 8'd0);
        wait_done(200);
        start_burst(2'd2, 16'h1111, 16'd3, 8'd0);
        wait_done(200);

        // Empty burst: flush only.
        start_burst(2'd1, 16'h1234, 16'd0, 8'd0);
        wait_done(200);

        // Most-negative amplitude in alternating mode wraps onto itself.
        start_burst(2'd3, 16'h8000, 16'd2, 8'd1);
        wait_done(200);

        // start re-asserted during EMIT and during FLUSH must be ignored.
        start_burst(2'd1, 16'h0123, 16'd5, 8'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
        repeat (3) @(negedge clk);
        check("no_second_burst", sb_q.size(), 32'd0);

        // Asynchronous reset in the middle of a step burst.
        start_burst(2'd1, 16'h0400, 16'd20, 8'd0);
        repeat (9) @(negedge clk);
        check("pre_reset_valid", {31'h0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        sb_q.delete();
        done_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset_idle");
        start_burst(2'd1, 16'h0400, 16'd3, 8'd1);
        wait_done(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
